modadd_nx_pipe: RTL and testbench
=================================

Name: modadd_nx_pipe

Overview:
- Parametrised successor to the 3-input partial-modular adder stage.
- Sums NUM_IN residues modulo an arbitrary MODULUS and fully reduces the result into [0, MODULUS); no partial-mod LUT or second reduction stage is needed.
- Per-input negation (modular subtract), input range checking, valid tracking and clock-enable stall are added.
- Sits in the TPU residue datapath as a drop-in modular accumulate/subtract unit per RNS digit channel.

Parameters:
- DATA_WIDTH, 18, residue width in bits.
- MODULUS, 262139, channel modulus; must satisfy 2 <= MODULUS <= 2^DATA_WIDTH.
- NUM_IN, 3, number of residue inputs; legal range 2..8.
- NEG_MASK, 3'b000 (NUM_IN bits), static mask; bit i=1 means input i is subtracted (modular negation).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- ce, input, 1, pipeline advance enable; 0 holds all stages.
- valid_in, input, 1, the in_data word is valid this cycle.
- in_data, input, NUM_IN*DATA_WIDTH, packed residues; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out, output, 1, result is valid.
- result, output, DATA_WIDTH, sum of inputs modulo MODULUS, in [0, MODULUS).
- range_err, output, 1, at least one input of this result was >= MODULUS.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
  - Reset clears all stage valids, valid_out, result and range_err to 0 on the next rising edge, regardless of ce.
  - Reset mid-operation discards in-flight data. No output pulse is produced for it.
- Pipeline: 3 register stages; latency 3 ce-qualified cycles from valid_in to valid_out. All stages advance only when ce=1. valid travels with data.
- Stage 1 (condition):
  - Per input i, err_i = (x_i >= MODULUS).
  - If NEG_MASK[i]=1, y_i = (x_i==0) ? 0 : MODULUS - x_i. Otherwise y_i = x_i.
  - Register y_i, the OR of all err_i, and valid.
  - Out-of-range inputs are conditioned as 0.
- Stage 2 (sum):
  - Register S = sum of y_i, width SW = DATA_WIDTH + clog2(NUM_IN). No overflow is possible because each y_i < MODULUS.
  - Pass err and valid forward.
- Stage 3 (reduce):
  - Compute in parallel S - k*MODULUS for k = 0..NUM_IN-1.
  - Select the candidate with the largest k whose subtraction does not go negative. Exactly one candidate lands in [0, MODULUS).
  - Constants k*MODULUS are computed at elaboration; no runtime multiplier.
  - Register result, range_err and valid_out.
- Error:
  - If err is set, result is forced to 0 and range_err=1 with valid_out=1.
  - range_err is only meaningful when valid_out=1. It is 0 when valid_out=0.
- Stall:
  - With ce=0, all registers including the outputs hold their values.
  - valid_in and in_data are ignored during ce=0.
  - Back-to-back valid_in with ce=1 gives one result per cycle.
- valid_in=0 bubbles: the stage data is don't-care, but valid_out must be 0 and range_err must be 0.
- Boundaries:
  - All inputs = MODULUS-1 gives the maximum sum; it must reduce correctly.
  - All inputs 0 gives result 0.
  - Negating 0 gives 0, never MODULUS.
  - MODULUS = 2^DATA_WIDTH must work; the range check then never fires.
- Elaboration error if MODULUS > 2^DATA_WIDTH, MODULUS < 2, or NUM_IN is outside 2..8.

Test Plan:
- Defaults, ce=1, in = {262138, 262138, 262138}, valid_in=1 -> 3 cycles later valid_out=1, result=262136, range_err=0.
- NEG_MASK=3'b010, in_a=5, in_b=7, in_c=0 -> result=262137. Same mask with in_b=0 -> result=5 (negation of 0 is 0).
- in_a=262139 (equal to MODULUS), others 1 -> valid_out=1, range_err=1, result=0. The following valid word {1,2,3} -> result=6, range_err=0.
- Stream of 4 back-to-back words {1,1,1}, {2,2,2}, {100000,100000,100000}, {0,0,0} with ce dropped low for 2 cycles after the second word:
  - Results are 3, 6, 37861, 0, in order.
  - Outputs are frozen during the stall.
  - Total latency is 3 + 2 cycles for words still in flight.
- Reset asserted for 1 cycle while 2 words are in flight, ce=0 at the same time -> valid_out=0, result=0 and range_err=0 the next cycle; no stale output appears afterwards.
- Randomised 10k words, NUM_IN=8, MODULUS=65521, DATA_WIDTH=16, random NEG_MASK -> result matches the golden model (signed sum mod MODULUS) on every valid_out.

Source files
------------

// File: rtl/modadd_nx_pipe.sv
// ---------------------------------------------------------------------------
// modadd_nx_pipe
//
// Three-stage modular adder for one RNS digit channel. Sums NUM_IN residues
// modulo MODULUS. Inputs flagged in NEG_MASK are subtracted instead of added.
// The result is fully reduced into [0, MODULUS).
//
// Stage 1 range-checks and conditions (optionally negates) each input.
// Stage 2 adds the conditioned residues.
// Stage 3 removes the right multiple of MODULUS and registers the outputs.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (wins over ce)
//   ce         in   pipeline advance enable; 0 holds every register
//   valid_in   in   in_data carries a word this cycle
//   in_data    in   NUM_IN packed residues, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_out  out  result/range_err carry a word
//   result     out  signed sum of inputs mod MODULUS, in [0, MODULUS)
//   range_err  out  some input of this word was >= MODULUS (result forced 0)
// ---------------------------------------------------------------------------
module modadd_nx_pipe #(
    parameter int                DATA_WIDTH = 18,
    parameter longint unsigned   MODULUS    = 262139,
    parameter int                NUM_IN     = 3,
    parameter logic [NUM_IN-1:0] NEG_MASK   = {NUM_IN{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic                         valid_out,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         range_err
);

    // Sum width: NUM_IN values each below 2^DATA_WIDTH cannot overflow this.
    localparam int SEL_W = $clog2(NUM_IN);
    localparam int SW    = DATA_WIDTH + SEL_W;

    // Modulus held one bit wider so MODULUS = 2^DATA_WIDTH is representable.
    localparam logic [DATA_WIDTH:0] MOD_X  = (DATA_WIDTH + 1)'(MODULUS);
    localparam logic [DATA_WIDTH:0] ZERO_X = {(DATA_WIDTH + 1){1'b0}};

    // Reject parameter sets the datapath cannot represent.
    if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
        $error("modadd_nx_pipe: NUM_IN must be in 2..8");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 62) begin : g_bad_width
        $error("modadd_nx_pipe: DATA_WIDTH must be in 1..62");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << DATA_WIDTH)) begin : g_bad_modulus
        $error("modadd_nx_pipe: MODULUS must satisfy 2 <= MODULUS <= 2^DATA_WIDTH");
    end

    // ---------------- stage 1: condition ----------------
    logic [DATA_WIDTH-1:0] y_s [NUM_IN];
    logic                  err_any_s;
    logic [DATA_WIDTH-1:0] s1_y_r [NUM_IN];
    logic                  s1_err_r;
    logic                  s1_valid_r;

    // Range-check each input; out-of-range inputs become 0, negated inputs
    // become MODULUS - x except that 0 stays 0 (keeps the value < MODULUS).
    always_comb begin
        logic [DATA_WIDTH:0] x_ext;
        err_any_s = 1'b0;
        x_ext     = ZERO_X;
        for (int i = 0; i < NUM_IN; i++) begin
            x_ext = {1'b0, in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            if (x_ext >= MOD_X) begin
                err_any_s = 1'b1;
                y_s[i]    = {DATA_WIDTH{1'b0}};
            end else if (NEG_MASK[i] && (x_ext != ZERO_X)) begin
                y_s[i] = DATA_WIDTH'(MOD_X - x_ext);
            end else begin
                y_s[i] = x_ext[DATA_WIDTH-1:0];
            end
        end
    end

    // Stage 1 registers: conditioned residues, error flag and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                s1_y_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (ce) begin
            s1_valid_r <= valid_in;
            s1_err_r   <= valid_in & err_any_s;
            for (int i = 0; i < NUM_IN; i++) begin
                s1_y_r[i] <= y_s[i];
            end
        end
    end

    // ---------------- stage 2: sum ----------------
    logic [SW-1:0] sum_s;
    logic [SW-1:0] s2_sum_r;
    logic          s2_err_r;
    logic          s2_valid_r;

    // Plain sum of the conditioned residues.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            sum_s = sum_s + {{SEL_W{1'b0}}, s1_y_r[i]};
        end
    end

    // Stage 2 registers: sum, error flag and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_err_r   <= 1'b0;
            s2_sum_r   <= {SW{1'b0}};
        end else if (ce) begin
            s2_valid_r <= s1_valid_r;
            s2_err_r   <= s1_err_r;
            s2_sum_r   <= sum_s;
        end
    end

    // ---------------- stage 3: reduce ----------------
    // The sum is below NUM_IN*MODULUS, so one of S - k*MODULUS for
    // k = 0..NUM_IN-1 lands in [0, MODULUS): the largest k without a borrow.
    logic [SW:0]           diff_s [NUM_IN];
    logic [NUM_IN-1:0]     fit_s;
    logic [DATA_WIDTH-1:0] red_s;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_cand
        localparam logic [SW:0] KMOD = (SW + 1)'(64'(k) * MODULUS);
        assign diff_s[k] = {1'b0, s2_sum_r} - KMOD;
        // Top bit of the widened difference is the borrow.
        assign fit_s[k]  = ~diff_s[k][SW];
    end

    // Fit flags are monotone (all ones up to some k), so the last fitting
    // candidate in ascending order is the reduced value.
    always_comb begin
        red_s = diff_s[0][DATA_WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            red_s = fit_s[k] ? diff_s[k][DATA_WIDTH-1:0] : red_s;
        end
    end

    // Output registers; errors and bubbles present a zero result and
    // range_err is only raised alongside valid_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            range_err <= 1'b0;
            result    <= {DATA_WIDTH{1'b0}};
        end else if (ce) begin
            valid_out <= s2_valid_r;
            range_err <= s2_valid_r & s2_err_r;
            result    <= (s2_valid_r & ~s2_err_r) ? red_s : {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_modadd_nx_pipe.sv
// ---------------------------------------------------------------------------
// tb_modadd_nx_pipe
//
// Four instances with different parameter sets share clk/reset/ce:
//   d0: default (18 bit, 262139, 3 inputs, no negation)
//   d1: default widths, NEG_MASK = 3'b010
//   d2: 16 bit, 65521, 8 inputs, NEG_MASK = 8'b1011_0010
//   d3: 8 bit, MODULUS = 256 = 2^8, 4 inputs, NEG_MASK = 4'b0101
// The driver pushes the expected word (signed sum mod MODULUS, computed with
// plain integer arithmetic) into a per-instance queue when a word is
// accepted; the monitor pops and compares whenever valid_out is presented.
// ---------------------------------------------------------------------------
module tb_modadd_nx_pipe;

    localparam int ND = 4;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic [ND-1:0] vin;
    logic [53:0]   in0;
    logic [53:0]   in1;
    logic [127:0]  in2;
    logic [31:0]   in3;
    logic [ND-1:0] vout;
    logic [ND-1:0] rerr;
    logic [17:0]   res0;
    logic [17:0]   res1;
    logic [15:0]   res2;
    logic [7:0]    res3;

    always #5 clk = ~clk;

    modadd_nx_pipe #(.DATA_WIDTH(18), .MODULUS(262139), .NUM_IN(3), .NEG_MASK(3'b000)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(vin[0]), .in_data(in0),
        .valid_out(vout[0]), .result(res0), .range_err(rerr[0]));
    modadd_nx_pipe #(.DATA_WIDTH(18), .MODULUS(262139), .NUM_IN(3), .NEG_MASK(3'b010)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(vin[1]), .in_data(in1),
        .valid_out(vout[1]), .result(res1), .range_err(rerr[1]));
    modadd_nx_pipe #(.DATA_WIDTH(16), .MODULUS(65521), .NUM_IN(8), .NEG_MASK(8'b1011_0010)) dut2 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(vin[2]), .in_data(in2),
        .valid_out(vout[2]), .result(res2), .range_err(rerr[2]));
    modadd_nx_pipe #(.DATA_WIDTH(8), .MODULUS(256), .NUM_IN(4), .NEG_MASK(4'b0101)) dut3 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(vin[3]), .in_data(in3),
        .valid_out(vout[3]), .result(res3), .range_err(rerr[3]));

    // Per-instance configuration as seen by the reference model.
    function automatic longint mod_of(input int d);
        case (d)
            0, 1:    return 262139;
            2:       return 65521;
            default: return 256;
        endcase
    endfunction
    function automatic int nin_of(input int d);
        case (d)
            0, 1:    return 3;
            2:       return 8;
            default: return 4;
        endcase
    endfunction
    function automatic int dw_of(input int d);
        case (d)
            0, 1:    return 18;
            2:       return 16;
            default: return 8;
        endcase
    endfunction
    function automatic int mask_of(input int d);
        case (d)
            0:       return 'h0;
            1:       return 'h2;
            2:       return 'hB2;
            default: return 'h5;
        endcase
    endfunction

    typedef struct {
        longint res;
        bit     err;
        longint edge_n;
    } exp_t;

    exp_t   sb [ND][$];
    longint xv [8];
    longint ce_edges = 0;
    bit     ce_q     = 1'b0;
    bit     rst_q    = 1'b0;
    bit     end_chk  = 1'b0;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     issued2  = 0;

    task automatic chk(input string name, input bit ok, input longint act, input longint expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Reference model: signed sum of the inputs reduced into [0, M).
    function automatic exp_t model(input int d);
        exp_t   e;
        longint m = mod_of(d);
        longint s = 0;
        longint r;
        e.err = 1'b0;
        for (int i = 0; i < nin_of(d); i++) begin
            if (xv[i] >= m) e.err = 1'b1;
            if (((mask_of(d) >> i) & 1) != 0) s = s - xv[i];
            else s = s + xv[i];
        end
        r = s % m;
        if (r < 0) r = r + m;
        e.res    = e.err ? 0 : r;
        e.edge_n = ce_edges + 3;
        return e;
    endfunction

    // Present xv[] to instance d; expectation is queued only if accepted.
    task automatic issue(input int d);
        for (int i = 0; i < nin_of(d); i++) begin
            case (d)
                0:       in0[i*18 +: 18] = 18'(xv[i]);
                1:       in1[i*18 +: 18] = 18'(xv[i]);
                2:       in2[i*16 +: 16] = 16'(xv[i]);
                default: in3[i*8 +: 8]   = 8'(xv[i]);
            endcase
        end
        vin[d] = 1'b1;
        if (ce === 1'b1 && reset === 1'b0) begin
            sb[d].push_back(model(d));
            if (d == 2) issued2++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        vin = '0;
    endtask

    task automatic set3(input longint a, input longint b, input longint c);
        xv[0] = a; xv[1] = b; xv[2] = c;
    endtask

    function automatic longint rand_x(input int d);
        longint m    = mod_of(d);
        longint maxv = (longint'(1) << dw_of(d)) - 1;
        int     r    = $urandom_range(63, 0);
        case (r)
            0:       return 0;
            1:       return m - 1;
            2:       return (m <= maxv) ? longint'($urandom_range(32'(maxv), 32'(m))) : m - 1;
            default: return longint'($urandom_range(32'(m - 1), 0));
        endcase
    endfunction

    // Monitor: sample ce/reset at the edge, check outputs half a cycle later.
    initial begin
        bit     pv [ND];
        bit     pe [ND];
        longint pr [ND];
        for (int d = 0; d < ND; d++) begin
            pv[d] = 1'b0; pe[d] = 1'b0; pr[d] = 0;
        end
        forever begin
            @(posedge clk);
            ce_q  = ce;
            rst_q = reset;
            if (ce && !reset) ce_edges++;
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                bit     v;
                bit     e;
                longint r;
                exp_t   x;
                v = vout[d];
                e = rerr[d];
                case (d)
                    0:       r = longint'(res0);
                    1:       r = longint'(res1);
                    2:       r = longint'(res2);
                    default: r = longint'(res3);
                endcase
                if (rst_q) begin
                    chk($sformatf("d%0d reset_clear", d), (v == 1'b0) && (e == 1'b0) && (r == 0),
                        {v, e, r[15:0]}, 0);
                    sb[d].delete();
                end else if (!ce_q) begin
                    chk($sformatf("d%0d stall_hold", d), (v == pv[d]) && (e == pe[d]) && (r == pr[d]),
                        r, pr[d]);
                end else if (v) begin
                    if (sb[d].size() == 0) begin
                        chk($sformatf("d%0d unexpected_output", d), 1'b0, r, -1);
                    end else begin
                        x = sb[d].pop_front();
                        chk($sformatf("d%0d result", d), r == x.res, r, x.res);
                        chk($sformatf("d%0d range_err", d), e == x.err, e, x.err);
                        chk($sformatf("d%0d latency_edge", d), ce_edges == x.edge_n, ce_edges, x.edge_n);
                    end
                end else begin
                    chk($sformatf("d%0d bubble_range_err", d), e == 1'b0, e, 0);
                end
                pv[d] = v; pe[d] = e; pr[d] = r;
            end
            if (end_chk) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("d%0d pending_words", d), sb[d].size() == 0, sb[d].size(), 0);
                end
                end_chk = 1'b0;
            end
        end
    end

    // Driver
    initial begin
        reset = 1'b1; ce = 1'b1; vin = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        for (int i = 0; i < 8; i++) xv[i] = 0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Maximum sum; subtract with and without a zero negation.
        set3(262138, 262138, 262138); issue(0);
        set3(5, 7, 0);                issue(1);
        for (int i = 0; i < 8; i++) xv[i] = 65520;
        issue(2);
        for (int i = 0; i < 4; i++) xv[i] = 255;
        issue(3);
        cycle();
        set3(262139, 1, 1); issue(0);
        set3(5, 0, 0);      issue(1);
        for (int i = 0; i < 8; i++) xv[i] = 0;
        issue(2);
        cycle();
        set3(1, 2, 3); issue(0);
        set3(0, 0, 0); issue(1);
        cycle();
        repeat (4) cycle();

        // Back-to-back stream with a two-cycle stall after the second word.
        set3(1, 1, 1); issue(0); cycle();
        set3(2, 2, 2); issue(0); cycle();
        ce = 1'b0; set3(9, 9, 9); issue(0); cycle();
        cycle();
        ce = 1'b1; set3(100000, 100000, 100000); issue(0); cycle();
        set3(0, 0, 0); issue(0); cycle();
        repeat (5) cycle();

        // Reset with two words in flight, ce low at the same time.
        set3(7, 8, 9);    issue(0); cycle();
        set3(10, 11, 12); issue(0); cycle();
        reset = 1'b1; ce = 1'b0; cycle();
        reset = 1'b0; ce = 1'b1; cycle();
        repeat (5) cycle();

        // Randomised traffic on every instance, random stalls.
        while (issued2 < 10000) begin
            ce = ($urandom_range(9, 0) != 0);
            for (int d = 0; d < ND; d++) begin
                if ($urandom_range(7, 0) != 0) begin
                    for (int i = 0; i < 8; i++) xv[i] = rand_x(d);
                    issue(d);
                end
            end
            cycle();
        end

        ce = 1'b1;
        repeat (8) cycle();
        end_chk = 1'b1;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
